// File: rtl/bus_io_responder_pkg.sv
// rtl/bus_io_responder_pkg.sv - register offsets, STATUS bit layout and timer state type
package bus_io_responder_pkg;

   localparam logic [1:0] OFF_TXDATA = 2'd0;
   localparam logic [1:0] OFF_RXDATA = 2'd1;
   localparam logic [1:0] OFF_STATUS = 2'd2;
   localparam logic [1:0] OFF_TIMER  = 2'd3;

   localparam int ST_EXPIRED = 0;
   localparam int ST_RX_FULL = 1;
   localparam int ST_TX_FULL = 2;
   localparam int ST_TX_OVF  = 3;
   localparam int ST_CNT_LSB = 4;

   typedef enum logic {T_IDLE, T_RUN} timer_state_t;

   function automatic logic [31:0] pack_status(input logic [3:0] cnt, input logic ovf,
                                               input logic full, input logic rxf,
                                               input logic exp);
      logic [31:0] s;
      s = '0;
      s[ST_CNT_LSB +: 4] = cnt;
      s[ST_TX_OVF]       = ovf;
      s[ST_TX_FULL]      = full;
      s[ST_RX_FULL]      = rxf;
      s[ST_EXPIRED]      = exp;
      return s;
   endfunction

endpackage

// File: rtl/bus_io_responder_sync_fifo.sv
// rtl/bus_io_responder_sync_fifo.sv - synchronous FIFO with occupancy count and overflow pulse
module bus_io_responder_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count,
   output logic             ovf
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
   assign do_push = push & (~full | do_pop);
   assign ovf     = push & full & ~do_pop;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/bus_io_responder.sv
// rtl/bus_io_responder.sv - external-bus responder: TX FIFO, RX holding register, status, timer
module bus_io_responder
   import bus_io_responder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_2000,
   parameter int          FIFO_DEPTH = 4,
   parameter int          CNT_W      = 3
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] ADDR,
   input  logic [31:0] Data_BUS_WRITE,
   input  logic        CS,
   input  logic        WR_RD,
   output logic [31:0] Data_BUS_READ,
   output logic [31:0] TX_DATA,
   output logic        TX_VALID,
   input  logic        TX_READY,
   input  logic [31:0] RX_DATA,
   input  logic        RX_VALID,
   output logic        RX_READY,
   output logic        IRQ
);

   logic             sel;
   logic [1:0]       off;
   logic             rd_en;
   logic             wr_en;
   logic             st_wr;
   logic             tmr_wr;
   logic             unused_bits;

   logic             tx_push;
   logic             tx_pop;
   logic             tx_full;
   logic             tx_empty;
   logic             tx_ovf_pulse;
   logic [CNT_W-1:0] tx_count;
   logic [7:0]       tx_count_ext;
   logic             tx_ovf;

   logic             rx_full;
   logic [31:0]      rx_data;
   logic             rx_pop;

   timer_state_t     t_state;
   timer_state_t     t_state_nxt;
   logic [31:0]      timer_cnt;
   logic [31:0]      timer_cnt_nxt;
   logic             exp_set;
   logic             timer_expired;

   logic [31:0]      rd_mux;

   assign sel         = CS & (ADDR[31:4] == BASE_ADDR[31:4]);
   assign off         = ADDR[3:2];
   assign unused_bits = ^ADDR[1:0];
   assign rd_en       = sel & ~WR_RD;
   assign wr_en       = sel & WR_RD;
   assign st_wr       = wr_en & (off == OFF_STATUS);
   assign tmr_wr      = wr_en & (off == OFF_TIMER);

   assign tx_push  = wr_en & (off == OFF_TXDATA);
   assign tx_pop   = TX_VALID & TX_READY;
   assign TX_VALID = ~tx_empty;

   bus_io_responder_sync_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_tx_fifo (
      .clk   (CLK),
      .rst   (RST),
      .push  (tx_push),
      .pop   (tx_pop),
      .wdata (Data_BUS_WRITE),
      .head  (TX_DATA),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count),
      .ovf   (tx_ovf_pulse)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         tx_ovf <= 1'b0;
      end else if (tx_ovf_pulse) begin
         tx_ovf <= 1'b1;
      end else if (st_wr & Data_BUS_WRITE[ST_TX_OVF]) begin
         tx_ovf <= 1'b0;
      end
   end

   // capture needs rx_full=0 and pop needs rx_full=1, so they never coincide
   assign RX_READY = ~rx_full;
   assign rx_pop   = rd_en & (off == OFF_RXDATA) & rx_full;

   always_ff @(posedge CLK) begin
      if (RST) begin
         rx_full <= 1'b0;
         rx_data <= '0;
      end else if (RX_VALID & RX_READY) begin
         rx_full <= 1'b1;
         rx_data <= RX_DATA;
      end else if (rx_pop) begin
         rx_full <= 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         t_state   <= T_IDLE;
         timer_cnt <= '0;
      end else begin
         t_state   <= t_state_nxt;
         timer_cnt <= timer_cnt_nxt;
      end
   end

   always_comb begin
      timer_cnt_nxt = timer_cnt;
      exp_set       = 1'b0;
      if (tmr_wr) begin
         timer_cnt_nxt = Data_BUS_WRITE;
      end else begin
         case (t_state)
            T_RUN: begin
               timer_cnt_nxt = timer_cnt - 32'd1;
               exp_set       = (timer_cnt == 32'd1);
            end
            default: timer_cnt_nxt = timer_cnt;
         endcase
      end
      t_state_nxt = (timer_cnt_nxt != '0) ? T_RUN : T_IDLE;
   end

   // a fresh expiry beats a software clear in the same cycle
   always_ff @(posedge CLK) begin
      if (RST) begin
         timer_expired <= 1'b0;
      end else if (exp_set) begin
         timer_expired <= 1'b1;
      end else if (st_wr & Data_BUS_WRITE[ST_EXPIRED]) begin
         timer_expired <= 1'b0;
      end
   end

   assign IRQ          = timer_expired;
   assign tx_count_ext = {{(8-CNT_W){1'b0}}, tx_count};

   always_comb begin
      rd_mux = '0;
      case (off)
         OFF_RXDATA: rd_mux = rx_data;
         OFF_STATUS: rd_mux = pack_status(tx_count_ext[3:0], tx_ovf, tx_full, rx_full,
                                          timer_expired);
         OFF_TIMER:  rd_mux = timer_cnt;
         default:    rd_mux = '0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         Data_BUS_READ <= '0;
      end else begin
         Data_BUS_READ <= rd_en ? rd_mux : 32'd0;
      end
   end

endmodule

// File: tb/tb_bus_io_responder.sv
// tb/tb_bus_io_responder.sv - directed and randomized checks of bus_io_responder against a queue model
module tb_bus_io_responder;

   localparam logic [31:0] BASE = 32'h0000_2000;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] ADDR;
   logic [31:0] Data_BUS_WRITE;
   logic        CS;
   logic        WR_RD;
   logic [31:0] Data_BUS_READ;
   logic [31:0] TX_DATA;
   logic        TX_VALID;
   logic        TX_READY;
   logic [31:0] RX_DATA;
   logic        RX_VALID;
   logic        RX_READY;
   logic        IRQ;

   always #5 CLK = ~CLK;

   bus_io_responder #(
      .BASE_ADDR  (BASE),
      .FIFO_DEPTH (4),
      .CNT_W      (3)
   ) dut (
      .CLK            (CLK),
      .RST            (RST),
      .ADDR           (ADDR),
      .Data_BUS_WRITE (Data_BUS_WRITE),
      .CS             (CS),
      .WR_RD          (WR_RD),
      .Data_BUS_READ  (Data_BUS_READ),
      .TX_DATA        (TX_DATA),
      .TX_VALID       (TX_VALID),
      .TX_READY       (TX_READY),
      .RX_DATA        (RX_DATA),
      .RX_VALID       (RX_VALID),
      .RX_READY       (RX_READY),
      .IRQ            (IRQ)
   );

   int total = 0;
   int bad   = 0;

   int unsigned mq[$];
   bit          m_ovf;
   bit          m_rxf;
   bit          m_exp;
   logic [31:0] m_rxd;
   logic [31:0] m_tmr;
   logic [31:0] m_rd;

   logic        txr;
   logic        rxv;
   logic [31:0] rxd;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_status();
      logic [31:0] s;
      s = (mq.size() << 4);
      if (m_ovf)          s = s + 32'h8;
      if (mq.size() == 4) s = s + 32'h4;
      if (m_rxf)          s = s + 32'h2;
      if (m_exp)          s = s + 32'h1;
      return s;
   endfunction

   task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic cs,
                       input logic wr, input logic rst);
      bit          sel;
      logic [1:0]  off;
      bit          pop;
      bit          push;
      bit          was_full;
      bit          ovf_set;
      bit          exp_set;
      ADDR = a; Data_BUS_WRITE = wd; CS = cs; WR_RD = wr; RST = rst;
      TX_READY = txr; RX_VALID = rxv; RX_DATA = rxd;
      sel = cs && (a[31:4] == BASE[31:4]);
      off = a[3:2];
      @(posedge CLK);
      #1;
      if (rst) begin
         mq.delete();
         m_ovf = 0; m_rxf = 0; m_exp = 0; m_rxd = 0; m_tmr = 0; m_rd = 0;
      end else begin
         m_rd = 0;
         if (sel && !wr) begin
            case (off)
               2'd1:    m_rd = m_rxd;
               2'd2:    m_rd = m_status();
               2'd3:    m_rd = m_tmr;
               default: m_rd = 0;
            endcase
         end
         pop      = (mq.size() > 0) && txr;
         push     = sel && wr && off == 2'd0;
         was_full = (mq.size() == 4);
         ovf_set  = 0;
         exp_set  = 0;
         if (pop) void'(mq.pop_front());
         if (push) begin
            if (!was_full || pop) mq.push_back(wd);
            else ovf_set = 1;
         end
         if (rxv && !m_rxf) begin
            m_rxd = rxd;
            m_rxf = 1;
         end else if (sel && !wr && off == 2'd1 && m_rxf) begin
            m_rxf = 0;
         end
         if (sel && wr && off == 2'd3) m_tmr = wd;
         else if (m_tmr != 0) begin
            if (m_tmr == 1) exp_set = 1;
            m_tmr = m_tmr - 1;
         end
         if (sel && wr && off == 2'd2) begin
            if (wd[0]) m_exp = 0;
            if (wd[3]) m_ovf = 0;
         end
         if (exp_set) m_exp = 1;
         if (ovf_set) m_ovf = 1;
      end
      chk("rd_data", Data_BUS_READ, m_rd);
      chk("tx_valid", {31'b0, TX_VALID}, {31'b0, mq.size() > 0});
      if (mq.size() > 0) chk("tx_data", TX_DATA, mq[0]);
      chk("rx_ready", {31'b0, RX_READY}, {31'b0, !m_rxf});
      chk("irq", {31'b0, IRQ}, {31'b0, m_exp});
   endtask

   task automatic idle();                                   step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0); endtask
   task automatic wr(input logic [31:0] a, input logic [31:0] d); step(a, d, 1'b1, 1'b1, 1'b0);       endtask
   task automatic rd(input logic [31:0] a);                 step(a, 32'h0, 1'b1, 1'b0, 1'b0);     endtask
   task automatic rst_cyc();                                step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1); endtask

   initial begin
      logic [31:0] a;
      logic [31:0] wd;
      txr = 0; rxv = 0; rxd = 0;
      rst_cyc();
      rst_cyc();
      rd(BASE + 32'h8);
      chk("reset_status", Data_BUS_READ, 32'h0);
      chk("reset_txv", {31'b0, TX_VALID}, 32'h0);
      chk("reset_rxr", {31'b0, RX_READY}, 32'h1);
      chk("reset_irq", {31'b0, IRQ}, 32'h0);

      for (int i = 1; i <= 5; i++) wr(BASE, 32'h11 * i);
      rd(BASE + 32'h8);
      chk("ovf_status", Data_BUS_READ, 32'h4C);
      txr = 1;
      for (int i = 1; i <= 4; i++) begin
         chk("drain_order", TX_DATA, 32'h11 * i);
         idle();
      end
      chk("drain_empty", {31'b0, TX_VALID}, 32'h0);

      wr(BASE + 32'h8, 32'h8);
      txr = 0;
      for (int i = 1; i <= 4; i++) wr(BASE, 32'hA0 + i);
      txr = 1;
      wr(BASE, 32'h99);
      txr = 0;
      rd(BASE + 32'h8);
      chk("full_push_pop", Data_BUS_READ, 32'h44);
      txr = 1;
      for (int i = 2; i <= 5; i++) begin
         chk("push_pop_order", TX_DATA, (i == 5) ? 32'h99 : 32'hA0 + i);
         idle();
      end

      rxv = 1; rxd = 32'hDEAD_BEEF;
      idle();
      rxv = 0;
      chk("rx_busy", {31'b0, RX_READY}, 32'h0);
      rd(BASE + 32'h4);
      chk("rx_read", Data_BUS_READ, 32'hDEAD_BEEF);
      chk("rx_free", {31'b0, RX_READY}, 32'h1);
      rd(BASE + 32'h4);
      chk("rx_stale", Data_BUS_READ, 32'hDEAD_BEEF);

      wr(BASE + 32'hC, 32'd3);
      idle(); idle();
      chk("tmr_early", {31'b0, IRQ}, 32'h0);
      idle();
      chk("tmr_expire", {31'b0, IRQ}, 32'h1);
      wr(BASE + 32'h8, 32'h1);
      chk("irq_clear", {31'b0, IRQ}, 32'h0);
      wr(BASE + 32'hC, 32'd4);
      idle(); idle();
      wr(BASE + 32'hC, 32'd5);
      for (int i = 0; i < 4; i++) idle();
      chk("reload_early", {31'b0, IRQ}, 32'h0);
      idle();
      chk("reload_expire", {31'b0, IRQ}, 32'h1);

      wr(BASE + 32'h10, 32'h77);
      rd(BASE + 32'h10);
      chk("oow_read", Data_BUS_READ, 32'h0);
      step(BASE, 32'h66, 1'b0, 1'b1, 1'b0);
      chk("cs_low_push", {31'b0, TX_VALID}, 32'h0);
      txr = 0;
      wr(BASE, 32'h1); wr(BASE, 32'h2);
      rst_cyc();
      chk("rst_flush", {31'b0, TX_VALID}, 32'h0);

      for (int i = 0; i < 1500; i++) begin
         txr = ($urandom_range(0, 2) != 0);
         rxv = ($urandom_range(0, 3) == 0);
         rxd = $urandom;
         case ($urandom_range(0, 5))
            4:       a = 32'h2010;
            5:       a = $urandom;
            default: a = BASE + 32'($urandom_range(0, 15));
         endcase
         wd = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 9));
         step(a, wd, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              $urandom_range(0, 199) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
